// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the programmable timer controller.
//   state_t        : controller FSM states (IDLE, RUN, PAUSE, DONE)
//   DEF_WIDTH      : default counter width
//   DEF_PRE_W      : default prescaler field width
package timer_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler for the timer: produces a step once every (limit+1)
// enabled cycles.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : synchronous clear of the divider count (wins over enable)
//   enable    : advance the divider this cycle
//   limit     : divisor minus one
//   step      : high in the enabled cycle where the divider reaches limit
module timer_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] limit,
  output logic             step
);

  logic [PRE_W-1:0] count;

  assign step = enable && (count == limit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= step ? '0 : count + PRE_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer controller: sequences a WIDTH-bit up-counter that runs
// 0..period, with prescaler, start/stop/pause control, one-shot or periodic
// reload and a sticky interrupt.
//   clk, rstn                         : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready               : config handshake
//   cfg_period/cfg_prescale/cfg_oneshot : config payload
//   start, stop                       : run control (stop wins when both high)
//   cnt                               : current count
//   busy                              : RUN or PAUSE
//   tick                              : one-cycle pulse after each wrap
//   irq, irq_ack                      : sticky interrupt and its clear
//   state                             : FSM state, exported for observation
//
// Config handshake: the payload is captured on a rising clk edge where
// cfg_valid and cfg_ready are both high. cfg_ready is high only in IDLE and
// DONE; a cfg_valid seen while cfg_ready is low is dropped, not queued.
// cfg_ready does not depend on cfg_valid.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tick,
  output logic             irq,
  input  logic             irq_ack,
  output state_t           state
);

  logic [WIDTH-1:0] period_q;
  logic [PRE_W-1:0] prescale_q;
  logic             oneshot_q;
  logic             idle_like;
  logic             launch;
  logic             pre_en;
  logic             step;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign cfg_ready = idle_like;
  assign busy      = (state == ST_RUN) || (state == ST_PAUSE);

  // A fresh run restarts the divider; a resume from PAUSE keeps its phase.
  assign launch = idle_like && start && !stop;
  // The divider is frozen on the edge that takes RUN into PAUSE.
  assign pre_en = (state == ST_RUN) && !stop;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (launch),
    .enable (pre_en),
    .limit  (prescale_q),
    .step   (step)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tick       <= 1'b0;
      irq        <= 1'b0;
      period_q   <= '1;
      prescale_q <= '0;
      oneshot_q  <= 1'b0;
    end else begin
      tick <= 1'b0;
      // A pending tick sets irq even if an ack arrives in the same cycle.
      irq  <= tick ? 1'b1 : (irq_ack ? 1'b0 : irq);

      // Shadows update on the same edge as a start, so that run sees them.
      if (cfg_valid && cfg_ready) begin
        period_q   <= cfg_period;
        prescale_q <= cfg_prescale;
        oneshot_q  <= cfg_oneshot;
      end

      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start && !stop) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_PAUSE;
          end else if (step) begin
            if (cnt == period_q) begin
              cnt  <= '0;
              tick <= 1'b1;
              if (oneshot_q) state <= ST_DONE;
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (start) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Testbench for timer_ctrl: directed table, multi-cycle corner sequences and
// randomized traffic checked against a count-of-active-cycles reference model.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;
  localparam int W     = WIDTH + 4;  // {cnt, busy, tick, irq, cfg_ready}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period = '0;
  logic [PRE_W-1:0] cfg_prescale = '0;
  logic             cfg_oneshot = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             tick;
  logic             irq;
  logic             irq_ack = 1'b0;
  state_t           dut_state;

  timer_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_oneshot  (cfg_oneshot),
    .start        (start),
    .stop         (stop),
    .cnt          (cnt),
    .busy         (busy),
    .tick         (tick),
    .irq          (irq),
    .irq_ack      (irq_ack),
    .state        (dut_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] dut_out();
    return {cnt, busy, tick, irq, cfg_ready};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got cnt=%0d busy=%b tick=%b irq=%b rdy=%b, expected cnt=%0d busy=%b tick=%b irq=%b rdy=%b",
               name, act[W-1:4], act[3], act[2], act[1], act[0],
               exp[W-1:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The run is described by n = number of RUN cycles in which counting was
  // allowed since the last start; the count is derived arithmetically.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode, m_n, m_per, m_pre;
  bit m_os, m_tick, m_irq;

  task automatic model_reset();
    m_mode = M_IDLE; m_n = 0; m_per = (1 << WIDTH) - 1; m_pre = 0;
    m_os = 0; m_tick = 0; m_irq = 0;
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] model_out();
    int c;
    bit running;
    running = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    c = running ? (m_n / (m_pre + 1)) % (m_per + 1) : 0;
    return {WIDTH'(c), running, m_tick, m_irq, (m_mode == M_IDLE) || (m_mode == M_DONE)};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit nt;
    bit ready;
    nt = 0;
    ready = (m_mode == M_IDLE) || (m_mode == M_DONE);
    m_irq = m_tick ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
    if (cfg_valid && ready) begin
      m_per = int'(cfg_period); m_pre = int'(cfg_prescale); m_os = cfg_oneshot;
    end
    case (m_mode)
      M_IDLE, M_DONE: if (start && !stop) begin m_mode = M_RUN; m_n = 0; end
      M_RUN: begin
        if (stop) m_mode = M_PAUSE;
        else begin
          m_n++;
          if ((m_n % (m_pre + 1) == 0) && ((m_n / (m_pre + 1)) % (m_per + 1) == 0)) begin
            nt = 1;
            if (m_os) begin m_mode = M_DONE; m_n = 0; end
          end
        end
      end
      M_PAUSE: begin
        if (stop) begin m_mode = M_IDLE; m_n = 0; end
        else if (start) m_mode = M_RUN;
      end
      default: m_mode = M_IDLE;
    endcase
    m_tick = nt;
    exp_q.push_back(model_out());
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic cv, input logic [WIDTH-1:0] per, input logic [PRE_W-1:0] pre,
                       input logic os, input logic st, input logic sp, input logic ack);
    cfg_valid = cv; cfg_period = per; cfg_prescale = pre; cfg_oneshot = os;
    start = st; stop = sp; irq_ack = ack;
    @(posedge clk);
    model_step();
    #1;
    if (exp_q.size() == 0) check_val("model_queue_empty", 0, 1);
    else check("model", dut_out(), exp_q.pop_front());
  endtask

  task automatic nop();
    apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cfg_valid = 0; start = 0; stop = 0; irq_ack = 0;
    #2;
    rstn = 1'b0;
    #1;
    check("reset_values", dut_out(), {WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b1});
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic cv; logic [WIDTH-1:0] per; logic [PRE_W-1:0] pre; logic os;
    logic st; logic sp; logic ack;
    logic [WIDTH-1:0] e_cnt; logic e_busy; logic e_tick; logic e_irq; logic e_rdy;
  } vec_t;

  localparam int NV = 23;
  vec_t vt[NV];

  initial begin
    int k, ticks, guard;

    // cv  per pre os st sp ack   cnt busy tick irq rdy
    vt[0]  = '{1, 2, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0};  // cfg + start same cycle
    vt[1]  = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1};  // one-shot wrap -> DONE
    vt[4]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1};  // ack clears irq
    vt[6]  = '{0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1};  // start&stop in DONE: no-op
    vt[7]  = '{0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0};  // pause
    vt[10] = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0};
    vt[11] = '{1, 9, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0};  // cfg ignored while busy
    vt[12] = '{0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0};  // resume
    vt[13] = '{0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0};
    vt[14] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1};  // old period still in force
    vt[15] = '{1, 0, 1, 0, 1, 0, 0,  0, 1, 0, 1, 0};  // period 0, prescale 1
    vt[16] = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0};
    vt[17] = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0};
    vt[18] = '{0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 0};  // ack with tick: irq stays
    vt[19] = '{0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0};
    vt[20] = '{0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1, 0};  // pause: tick low
    vt[21] = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1};  // stop in PAUSE -> IDLE
    vt[22] = '{0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 1};  // start&stop in IDLE

    model_reset();
    do_reset();

    for (int i = 0; i < NV; i++) begin
      apply(vt[i].cv, vt[i].per, vt[i].pre, vt[i].os, vt[i].st, vt[i].sp, vt[i].ack);
      check($sformatf("vec%0d", i), dut_out(),
            {vt[i].e_cnt, vt[i].e_busy, vt[i].e_tick, vt[i].e_irq, vt[i].e_rdy});
      if (i == 3) check_val("oneshot_state_done", int'(dut_state), int'(ST_DONE));
    end

    // Free-running defaults: 16-cycle wrap, irq, ack.
    do_reset();
    apply(0, '0, '0, 0, 1, 0, 0);
    ticks = 0;
    for (int i = 1; i <= 50; i++) begin
      nop();
      if (tick) ticks++;
      if (i <= 20) check_val($sformatf("free_cnt%0d", i), int'(cnt), i % 16);
    end
    check_val("free_tick_count", ticks, 3);
    check_val("free_irq_set", int'(irq), 1);
    apply(0, '0, '0, 0, 0, 0, 1);
    check_val("free_irq_ack", int'(irq), 0);

    // Pause holds, resume continues, stop-stop returns to IDLE.
    do_reset();
    apply(1, 4'd10, 4'd1, 0, 1, 0, 0);
    guard = 0;
    while (cnt != 4'd7 && guard < 100) begin nop(); guard++; end
    check_val("reach_cnt7", int'(cnt), 7);
    apply(0, '0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      nop();
      check_val("pause_hold_cnt", int'(cnt), 7);
      check_val("pause_busy", int'(busy), 1);
    end
    apply(0, '0, '0, 0, 1, 0, 0);
    guard = 0;
    while (cnt == 4'd7 && guard < 10) begin nop(); guard++; end
    check_val("resume_next", int'(cnt), 8);
    apply(0, '0, '0, 0, 0, 1, 0);
    apply(0, '0, '0, 0, 0, 1, 0);
    check_val("stopstop_cnt", int'(cnt), 0);
    check_val("stopstop_busy", int'(busy), 0);

    // Config + start together, period 3: first tick after 4 steps, 1 cycle wide.
    apply(1, 4'd3, 4'd0, 0, 1, 0, 0);
    k = 0;
    guard = 0;
    while (!tick && guard < 20) begin nop(); guard++; end
    k = guard;
    check_val("p3_first_tick_cycles", k, 4);
    nop();
    check_val("p3_tick_width", int'(tick), 0);

    // Asynchronous reset mid-run at cnt=9.
    do_reset();
    apply(0, '0, '0, 0, 1, 0, 0);
    guard = 0;
    while (cnt != 4'd9 && guard < 30) begin nop(); guard++; end
    check_val("reach_cnt9", int'(cnt), 9);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", dut_out(), {WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b1});
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 3) == 0,
            WIDTH'($urandom_range(0, 6)),
            PRE_W'($urandom_range(0, 2)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
